// File: rtl/mem_arb_pkg.sv
// Purpose: shared types for the two-port main_mem arbiter.
// Latency: none (types and constants only).
// Backpressure: n/a.
package mem_arb_pkg;

  localparam int NUM_PORTS = 2;

  typedef logic port_idx_t;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rr_pick2.sv
// Purpose: two-requester round-robin picker; a tie goes to the port that was not granted last.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to act on the pick.
//
// Ports:
//   req    - pending requests, one bit per port
//   last   - most recently granted port
//   valid  - at least one port is pending
//   winner - chosen port, meaningful only when valid = 1
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic [NUM_PORTS-1:0] req,
  input  port_idx_t            last,
  output logic                 valid,
  output port_idx_t            winner
);

  always_comb begin
    valid  = |req;
    // With a single requester, req[1] is the index of that requester.
    winner = req[1];
    if (&req) begin
      winner = ~last;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Purpose: shares one main_mem between I-cache (port 0) and D-cache (port 1), whole transactions round-robin.
// Latency: request seen in IDLE drives main_mem next cycle; port gnt is the same-cycle copy of mem_gnt.
// Backpressure: requests are level-held until gnt; a non-owner waits, and one idle bubble follows every grant.
//
// Ports (k = 0, 1):
//   clk, rst              - clock; asynchronous active-high reset
//   pk_rd_req, pk_wr_req  - line read / write requests, held until pk_gnt
//   pk_addr, pk_wr_line   - line address and write data
//   pk_gnt                - one-cycle completion pulse to the owner
//   pk_rd_line            - last line read by port k, held until its next read completes
//   pk_xfer_cnt           - completed transactions of port k, wrapping
//   mem_*                 - request, address, write data to main_mem; all zero in IDLE
//   mem_gnt, mem_rd_line  - completion and read data from main_mem
//   busy, owner           - a transaction is owned, and by which port
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter  int LINE_ADDR_LEN = 3,
  parameter  int ADDR_LEN      = 9,
  parameter  int CNT_W         = 16,
  localparam int LINE_SIZE     = 1 << LINE_ADDR_LEN
) (
  input  logic                          clk,
  input  logic                          rst,

  input  logic                          p0_rd_req,
  input  logic                          p0_wr_req,
  input  logic [ADDR_LEN-1:0]           p0_addr,
  input  logic [LINE_SIZE-1:0][31:0]    p0_wr_line,
  output logic                          p0_gnt,
  output logic [LINE_SIZE-1:0][31:0]    p0_rd_line,
  output logic [CNT_W-1:0]              p0_xfer_cnt,

  input  logic                          p1_rd_req,
  input  logic                          p1_wr_req,
  input  logic [ADDR_LEN-1:0]           p1_addr,
  input  logic [LINE_SIZE-1:0][31:0]    p1_wr_line,
  output logic                          p1_gnt,
  output logic [LINE_SIZE-1:0][31:0]    p1_rd_line,
  output logic [CNT_W-1:0]              p1_xfer_cnt,

  output logic                          mem_rd_req,
  output logic                          mem_wr_req,
  output logic [ADDR_LEN-1:0]           mem_addr,
  output logic [LINE_SIZE-1:0][31:0]    mem_wr_line,
  input  logic                          mem_gnt,
  input  logic [LINE_SIZE-1:0][31:0]    mem_rd_line,

  output logic                          busy,
  output logic                          owner
);

  arb_state_t state_q, state_d;
  port_idx_t  owner_q;
  port_idx_t  last_q;

  logic [LINE_SIZE-1:0][31:0] rd_line_q [NUM_PORTS];
  logic [CNT_W-1:0]           cnt_q     [NUM_PORTS];

  logic [NUM_PORTS-1:0] rd_req;
  logic [NUM_PORTS-1:0] wr_req;
  logic [NUM_PORTS-1:0] pend;
  logic [NUM_PORTS-1:0] gnt;

  logic      pick_vld;
  port_idx_t pick_winner;

  logic in_own;
  logic own_rd;
  logic own_wr;
  logic own_active;
  logic xfer_done;

  assign rd_req = {p1_rd_req, p0_rd_req};
  assign wr_req = {p1_wr_req, p0_wr_req};
  assign pend   = rd_req | wr_req;

  rr_pick2 u_pick (
    .req    (pend),
    .last   (last_q),
    .valid  (pick_vld),
    .winner (pick_winner)
  );

  assign in_own     = (state_q == OWN);
  assign own_rd     = rd_req[owner_q];
  assign own_wr     = wr_req[owner_q];
  assign own_active = own_rd | own_wr;
  // An owner that has already dropped its request has nothing to complete,
  // so a coincident mem_gnt is not forwarded or counted.
  assign xfer_done  = in_own & own_active & mem_gnt;

  // main_mem sees the owner's request only while OWN; write wins over read.
  assign mem_wr_req  = in_own & own_wr;
  assign mem_rd_req  = in_own & own_rd & ~own_wr;
  assign mem_addr    = in_own ? (owner_q ? p1_addr : p0_addr) : '0;
  assign mem_wr_line = in_own ? (owner_q ? p1_wr_line : p0_wr_line) : '0;

  always_comb begin
    gnt = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      gnt[k] = xfer_done && (owner_q == port_idx_t'(k));
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (pick_vld) state_d = OWN;
      OWN:  if (!own_active || mem_gnt) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      // Port 0 wins the first tie after reset.
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && pick_vld) begin
        owner_q <= pick_winner;
      end
      if (xfer_done) begin
        last_q <= owner_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_PORTS; k++) begin
        rd_line_q[k] <= '0;
        cnt_q[k]     <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_PORTS; k++) begin
        if (gnt[k]) begin
          cnt_q[k] <= cnt_q[k] + CNT_W'(1);
          // Only reads refresh the buffer, so a write-back leaves the last refill intact.
          if (mem_rd_req) begin
            rd_line_q[k] <= mem_rd_line;
          end
        end
      end
    end
  end

  assign p0_gnt      = gnt[0];
  assign p1_gnt      = gnt[1];
  assign p0_rd_line  = rd_line_q[0];
  assign p1_rd_line  = rd_line_q[1];
  assign p0_xfer_cnt = cnt_q[0];
  assign p1_xfer_cnt = cnt_q[1];
  assign busy        = in_own;
  assign owner       = owner_q;

endmodule
